// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer <-> memory/datapath signal bundle
interface cpu_sequencer_if;
    logic        run;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_ack;
    logic        zero;
    logic [15:0] reg_a_val;
    logic [15:0] pc;
    logic        imem_req;
    logic [31:0] ir;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic [2:0]  state;
    logic        fault;

    modport master (
        input  run, imem_rdata, imem_ack, dmem_ack, zero, reg_a_val,
        output pc, imem_req, ir, dmem_req, dmem_we, rf_we, state, fault
    );

    modport slave (
        output run, imem_rdata, imem_ack, dmem_ack, zero, reg_a_val,
        input  pc, imem_req, ir, dmem_req, dmem_we, rf_we, state, fault
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/exec/mem/wb control sequencer; optional watchdog under SEQ_WATCHDOG_EN
module cpu_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    cpu_sequencer_if.master   io_bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [31:0] r_ir;
    logic [31:0] w_ir_next;
    logic        r_dmem_we;
    logic        w_dmem_we_next;
    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_rf_we;
    logic        w_timeout;
    logic [4:0]  w_op;
    logic [15:0] w_off;
    logic [15:0] w_pc_inc;
    logic [15:0] w_pc_rel;

    assign w_op     = r_ir[31:27];
    assign w_off    = r_ir[18:3];
    assign w_pc_inc = r_pc + 16'd1;
    assign w_pc_rel = r_pc + w_off;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Timeout fires on the TIMEOUT-th waiting cycle; an ack in that cycle is checked first
    assign w_timeout    = (r_wd_cnt == WD_W'(TIMEOUT - 1));
    assign io_bus.fault = (r_state == S_FAULT);

    // Wait-cycle counter: runs in FETCH/MEM, restarts on every state change
    always_ff @(posedge clk) begin
        if (rst || (w_state_next != r_state)) begin
            r_wd_cnt <= '0;
        end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end
`else
    // Without the watchdog, waits are unbounded; TIMEOUT has no effect on this build
    assign w_timeout    = 1'b0 && (TIMEOUT > 0);
    assign io_bus.fault = 1'b0;
`endif

    // State and datapath-control registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= 16'd0;
            r_ir      <= 32'd0;
            r_dmem_we <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_ir      <= w_ir_next;
            r_dmem_we <= w_dmem_we_next;
        end
    end

    // Next-state, pc update and request/strobe decode
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ir_next      = r_ir;
        w_dmem_we_next = r_dmem_we;
        w_imem_req     = 1'b0;
        w_dmem_req     = 1'b0;
        w_rf_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (io_bus.imem_ack) begin
                    w_ir_next    = io_bus.imem_rdata;
                    w_state_next = S_EXEC;
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                end
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                case (w_op) inside
                    5'd0: begin
                        w_state_next = S_IDLE;
                    end
                    [5'd2:5'd16]: begin
                        w_state_next = S_WB;
                    end
                    5'd17: begin
                        w_dmem_we_next = 1'b0;
                        w_state_next   = S_MEM;
                    end
                    5'd18: begin
                        w_dmem_we_next = 1'b1;
                        w_state_next   = S_MEM;
                    end
                    5'd19: w_pc_next = io_bus.reg_a_val;
                    5'd21: w_pc_next = io_bus.zero ? w_pc_rel : w_pc_inc;
                    5'd22: w_pc_next = io_bus.zero ? w_pc_inc : w_pc_rel;
                    5'd23: w_pc_next = w_pc_rel;
                    default: w_pc_next = w_pc_inc;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                if (io_bus.dmem_ack) begin
                    if (r_dmem_we) begin
                        w_pc_next    = w_pc_inc;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign io_bus.pc       = r_pc;
    assign io_bus.ir       = r_ir;
    assign io_bus.imem_req = w_imem_req;
    assign io_bus.dmem_req = w_dmem_req;
    assign io_bus.dmem_we  = r_dmem_we;
    assign io_bus.rf_we    = w_rf_we;
    assign io_bus.state    = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed plus randomized checks of cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;

    localparam int TIMEOUT = 15;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_pc;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural next-pc of one instruction
    function automatic logic [15:0] ref_pc(input logic [4:0] op, input logic [15:0] pc,
                                           input logic [15:0] off, input logic z,
                                           input logic [15:0] ra);
        if (op == 5'd0)  return pc;
        if (op == 5'd19) return ra;
        if (op == 5'd21) return z ? pc + off : pc + 16'd1;
        if (op == 5'd22) return z ? pc + 16'd1 : pc + off;
        if (op == 5'd23) return pc + off;
        return pc + 16'd1;
    endfunction

    task automatic start();
        chk("idle_before_run", bus.state, ST_IDLE);
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("fetch_after_run", bus.state, ST_FETCH);
        chk("fetch_pc_after_run", bus.pc, m_pc);
    endtask

    task automatic fetch_phase(input logic [31:0] instr, input logic z, input logic [15:0] ra,
                               input int ack_dly, output int cyc);
        int bad;
        bad = 0;
        cyc = 0;
        for (int i = 0; i < ack_dly; i++) begin
            if (bus.state !== ST_FETCH || bus.imem_req !== 1'b1) bad++;
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            tick();
            cyc++;
        end
        if (bus.state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.pc !== m_pc) bad++;
        chk("fetch_wait", bad, 0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr;
        bus.zero       = z;
        bus.reg_a_val  = ra;
        tick();
        cyc++;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("exec_state", bus.state, ST_EXEC);
        chk("ir_load", bus.ir, instr);
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [15:0] off, input logic z,
                             input logic [15:0] ra, input int ack_dly, input int mem_dly);
        logic [31:0] instr;
        logic [7:0]  mid;
        logic [2:0]  lo;
        logic        is_alu, is_ld, is_st;
        logic [15:0] exp_pc;
        logic [2:0]  exp_state;
        int cyc, rfw, dreq, webad, mem_seen, guard, exp_cyc;
        mid = 8'($urandom);
        lo  = 3'($urandom);
        instr  = {op, mid, off, lo};
        is_alu = (op >= 5'd2) && (op <= 5'd16);
        is_ld  = (op == 5'd17);
        is_st  = (op == 5'd18);
        exp_pc    = ref_pc(op, m_pc, off, z, ra);
        exp_state = (op == 5'd0) ? ST_IDLE : ST_FETCH;
        exp_cyc   = ack_dly + 2 + (is_alu ? 1 : 0) + (is_ld ? mem_dly + 2 : 0) + (is_st ? mem_dly + 1 : 0);
        rfw = 0; dreq = 0; webad = 0; mem_seen = 0; guard = 0;
        fetch_phase(instr, z, ra, ack_dly, cyc);
        do begin
            if (bus.rf_we === 1'b1) rfw++;
            if (bus.dmem_req === 1'b1) begin
                dreq++;
                if (bus.dmem_we !== is_st) webad++;
            end
            bus.dmem_ack = (bus.state === ST_MEM) ? (mem_seen == mem_dly) : 1'($urandom);
            if (bus.state === ST_MEM) mem_seen++;
            bus.imem_ack = 1'($urandom);
            tick();
            cyc++;
            guard++;
            bus.dmem_ack = 1'b0;
            bus.imem_ack = 1'b0;
        end while (bus.state !== ST_FETCH && bus.state !== ST_IDLE && guard < 200);
        chk($sformatf("bounded_op%0d", op), (guard < 200), 1);
        chk($sformatf("end_state_op%0d", op), bus.state, exp_state);
        chk($sformatf("pc_op%0d", op), bus.pc, exp_pc);
        chk($sformatf("rf_we_pulses_op%0d", op), rfw, (is_alu || is_ld) ? 1 : 0);
        chk($sformatf("dmem_req_cycles_op%0d", op), dreq, (is_ld || is_st) ? mem_dly + 1 : 0);
        chk($sformatf("dmem_we_op%0d", op), webad, 0);
        chk($sformatf("cycles_op%0d", op), cyc, exp_cyc);
        m_pc = exp_pc;
    endtask

    task automatic goto_pc(input logic [15:0] target);
        run_instr(5'd23, target - m_pc, 1'($urandom), 16'($urandom), $urandom_range(0, 2), 0);
    endtask

    initial begin
        int cyc;
        int bad;
        logic [4:0] rop;

        rst            = 1'b1;
        bus.run        = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        bus.imem_ack   = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.zero       = 1'b0;
        bus.reg_a_val  = 16'h0;
        tick();
        tick();
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst_pc", bus.pc, 16'h0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_dmem_req", bus.dmem_req, 1'b0);
        chk("rst_dmem_we", bus.dmem_we, 1'b0);
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        bus.run      = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst          = 1'b0;
        m_pc         = 16'h0;
        tick();
        chk("idle_hold_no_run", bus.state, ST_IDLE);

        // ALU op at pc 0, ack after 2 cycles: 5 cycles FETCH to FETCH
        start();
        run_instr(5'd3, 16'($urandom), 1'($urandom), 16'($urandom), 2, 0);

        // Load and store at pc 4
        goto_pc(16'h0004);
        run_instr(5'd17, 16'($urandom), 1'($urandom), 16'($urandom), 1, 2);
        goto_pc(16'h0004);
        run_instr(5'd18, 16'($urandom), 1'($urandom), 16'($urandom), 0, 2);

        // Branches at 0x0020 and register jump
        goto_pc(16'h0020);
        run_instr(5'd21, 16'h0010, 1'b1, 16'($urandom), 1, 0);
        goto_pc(16'h0020);
        run_instr(5'd21, 16'h0010, 1'b0, 16'($urandom), 0, 0);
        goto_pc(16'h0020);
        run_instr(5'd22, 16'h0010, 1'b1, 16'($urandom), 0, 0);
        goto_pc(16'h0020);
        run_instr(5'd22, 16'h0010, 1'b0, 16'($urandom), 2, 0);
        run_instr(5'd19, 16'($urandom), 1'($urandom), 16'h1234, 1, 0);

        // pc wrap, halt, restart at the same pc
        run_instr(5'd19, 16'($urandom), 1'($urandom), 16'hFFFF, 0, 0);
        run_instr(5'd23, 16'h0002, 1'($urandom), 16'($urandom), 0, 0);
        goto_pc(16'h0007);
        run_instr(5'd0, 16'($urandom), 1'($urandom), 16'($urandom), 1, 0);
        start();
        run_instr(5'd1, 16'($urandom), 1'($urandom), 16'($urandom), 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            rop = 5'($urandom_range(0, 31));
            run_instr(rop, 16'($urandom), 1'($urandom), 16'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4));
            if (bus.state === ST_IDLE) start();
        end

        // Long fetch wait: watchdog fault or unbounded wait
`ifdef SEQ_WATCHDOG_EN
        bad = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (bus.state !== ST_FETCH || bus.imem_req !== 1'b1) bad++;
        end
        chk("wd_pre_timeout", bad, 0);
        tick();
        chk("wd_fault_state", bus.state, ST_FAULT);
        chk("wd_fault_flag", bus.fault, 1'b1);
        chk("wd_fault_imem_req", bus.imem_req, 1'b0);
        chk("wd_fault_dmem_req", bus.dmem_req, 1'b0);
        bus.imem_ack = 1'b1;
        bus.run      = 1'b1;
        tick();
        tick();
        tick();
        bus.imem_ack = 1'b0;
        bus.run      = 1'b0;
        chk("wd_fault_sticky", bus.state, ST_FAULT);
        chk("wd_fault_flag_sticky", bus.fault, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 16'h0;
        chk("wd_rst_state", bus.state, ST_IDLE);
        chk("wd_rst_fault", bus.fault, 1'b0);
        start();
        run_instr(5'd1, 16'($urandom), 1'($urandom), 16'($urandom), TIMEOUT - 1, 0);
`else
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.fault !== 1'b0) bad++;
        end
        chk("unbounded_fetch_wait", bad, 0);
        run_instr(5'd1, 16'($urandom), 1'($urandom), 16'($urandom), 0, 0);
`endif

        // Reset colliding with dmem_ack during a load
        if (bus.state === ST_IDLE) start();
        fetch_phase({5'd17, 8'h00, 16'h0000, 3'h0}, 1'b0, 16'h0, 1, cyc);
        tick();
        chk("s6_in_mem", bus.state, ST_MEM);
        chk("s6_dmem_req", bus.dmem_req, 1'b1);
        rst          = 1'b1;
        bus.dmem_ack = 1'b1;
        tick();
        rst          = 1'b0;
        bus.dmem_ack = 1'b0;
        m_pc         = 16'h0;
        chk("s6_state", bus.state, ST_IDLE);
        chk("s6_pc", bus.pc, 16'h0);
        chk("s6_rf_we", bus.rf_we, 1'b0);
        chk("s6_dmem_req_off", bus.dmem_req, 1'b0);
        chk("s6_dmem_we", bus.dmem_we, 1'b0);
        tick();
        chk("s6_rf_we_next", bus.rf_we, 1'b0);
        chk("s6_state_next", bus.state, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum wait cycles for a memory ack before fault (used only with SEQ_WATCHDOG_EN).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run  in  1  level; starts execution from IDLE.
REQ-005 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-006 imem_ack  in  1  instruction fetch complete.
REQ-007 dmem_ack  in  1  data access complete.
REQ-008 zero  in  1  ALU zero flag from the datapath.
REQ-009 reg_a_val  in  16  register-file A-port value, the jmr target.
REQ-010 pc  out  16  program counter, which is also the instruction address.
REQ-011 imem_req  out  1  fetch request.
REQ-012 ir  out  32  instruction register; drives the decoder op_code.
REQ-013 dmem_req  out  1  data access request.
REQ-014 dmem_we  out  1  1 = store, 0 = load; meaningful only while dmem_req=1.
REQ-015 rf_we  out  1  one-cycle register-file write strobe.
REQ-016 state  out  3  current state encoding.
REQ-017 fault  out  1  sticky watchdog fault flag.

Function
REQ-018 The state encodings SHALL be IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, FAULT=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-019 IDLE SHALL go to FETCH when run=1 and SHALL otherwise hold.
REQ-020 In FETCH, imem_req SHALL be 1; on imem_ack=1 the block SHALL load ir with imem_rdata and go to EXEC.
- imem_ack is ignored in every other state.
REQ-021 EXEC SHALL last exactly one cycle and SHALL decode ir[31:27] as op; the 16-bit offset is off = ir[18:3].
REQ-022 For op 2..16 (ALU/immediate): go to WB.
REQ-023 For op 17 (ld): go to MEM with dmem_we=0.
- On dmem_ack=1, go to WB.
REQ-024 For op 18 (st): go to MEM with dmem_we=1.
- On dmem_ack=1, set pc = pc+1 and go to FETCH.
REQ-025 For op 21 (bz): pc = pc+off if zero=1, else pc = pc+1; then go to FETCH.
REQ-026 For op 22 (bnz): pc = pc+off if zero=0, else pc = pc+1; then go to FETCH.
REQ-027 For op 23 (jmp): pc = pc+off; then go to FETCH.
REQ-028 For op 19 (jmr): pc = reg_a_val; then go to FETCH.
REQ-029 For op 0 (halt): pc is unchanged; go to IDLE.
REQ-030 For op 1, 20, 24..31: pc = pc+1; go to FETCH.
REQ-031 In WB, rf_we SHALL be 1 for exactly one cycle; the block SHALL then set pc = pc+1 and go to FETCH.
REQ-032 All pc arithmetic SHALL be modulo 2^16 (0xFFFF+1 = 0x0000); off is unsigned.
REQ-033 dmem_req SHALL be 1 only in MEM.
- dmem_we SHALL be held stable for the whole MEM stay.
REQ-034 A request SHALL stay asserted until its ack arrives; it SHALL never be dropped early.
REQ-035 Dropping run mid-program SHALL have no effect; only op 0 returns the block to IDLE.

Reset
REQ-036 rst=1 SHALL force, on the next edge, state=IDLE, pc=0, ir=0, imem_req=0, dmem_req=0, dmem_we=0, rf_we=0, fault=0 and clear the watchdog counter.
REQ-037 rst SHALL take priority over every other event, including an ack in the same cycle and reset during MEM; any in-flight access is abandoned.

Configuration
REQ-038 Macro SEQ_WATCHDOG_EN defined: a counter SHALL run while the block is in FETCH or MEM and SHALL clear on every state change.
- If the counter reaches TIMEOUT with no ack, the block SHALL go to FAULT: fault=1, all requests 0, held until rst.
- An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win.
REQ-039 Macro SEQ_WATCHDOG_EN undefined: no counter; waits are unbounded, FAULT is unreachable and fault is tied to 0.

Verification
REQ-040 Scenario 1: reset, run=1, imem returns op=3 (add) at pc 0 with ack after 2 cycles -> rf_we pulses once, pc=1, FETCH re-entered; total 5 cycles from FETCH to FETCH.
REQ-041 Scenario 2: ld at pc 4 with dmem_ack after 3 cycles -> dmem_req=1 and dmem_we=0 for 3 cycles, then rf_we for 1 cycle, pc=5; st -> no rf_we, pc=5.
REQ-042 Scenario 3: bz off=0x0010 at pc 0x0020: zero=1 -> pc=0x0030; zero=0 -> pc=0x0021; bnz with the same stimulus gives the opposite results; jmr with reg_a_val=0x1234 -> pc=0x1234.
REQ-043 Scenario 4: jmp off=0x0002 at pc 0xFFFF -> pc=0x0001; halt at pc 7 -> state=IDLE, pc=7; run=1 -> the fetch at pc 7 is repeated.
REQ-044 Scenario 5: with SEQ_WATCHDOG_EN, TIMEOUT=15 and imem_ack never asserted -> FAULT after 15 FETCH cycles with fault=1 and imem_req=0; an ack arriving in cycle 15 proceeds to EXEC; without the macro the block waits indefinitely.
REQ-045 Scenario 6: rst asserted in the same cycle as dmem_ack during MEM -> IDLE, pc=0, no rf_we pulse.
